// File: rtl/neg_2s_pkg.sv
// -----------------------------------------------------------------------------
// neg_2s_pkg
//   Shared definitions for the conditional two's-complement negator datapath.
//   DATA_W  : datapath word width (16)
//   MIN_NEG : most-negative representable word; its negation is not
//             representable and wraps back to itself
//   word_t  : one datapath word
// -----------------------------------------------------------------------------
package neg_2s_pkg;

   localparam int DATA_W = 16;
   localparam logic [DATA_W-1:0] MIN_NEG = 16'h8000;

   typedef logic [DATA_W-1:0] word_t;

endpackage : neg_2s_pkg

// File: rtl/inc_16b.sv
// -----------------------------------------------------------------------------
// inc_16b
//   Ripple incrementer built from a chain of half adders: sum = a + cin.
//   With cin = 1 this is a+1; with cin = 0 the word passes straight through.
//
// Ports
//   a    in   W   operand
//   cin  in   1   carry into bit 0 (the "+1")
//   sum  out  W   a + cin, truncated to W bits
//   cout out  1   carry out of the MSB
// -----------------------------------------------------------------------------
module inc_16b
   import neg_2s_pkg::*;
#(
   parameter int W = DATA_W
) (
   input  logic [W-1:0] a,
   input  logic         cin,
   output logic [W-1:0] sum,
   output logic         cout
);

   // carry_w[i] is the carry into bit i; carry_w[W] leaves the MSB.
   logic [W:0] carry_w;

   assign carry_w[0] = cin;

   generate
      for (genvar gi = 0; gi < W; gi++) begin : g_half_add
         assign sum[gi]         = a[gi] ^ carry_w[gi];
         assign carry_w[gi + 1] = a[gi] & carry_w[gi];
      end
   endgenerate

   assign cout = carry_w[W];

endmodule : inc_16b

// File: rtl/neg_twos_16b.sv
// -----------------------------------------------------------------------------
// neg_twos_16b
//   Conditional two's-complement negator with one registered pipeline stage.
//   negBit = 1 : out = -in (mod 2^WIDTH)
//   negBit = 0 : out = in
//   Used on the ALU operand path so that subtract becomes add-of-negated.
//
// Ports
//   clk     in   1      clock, all state updates on the rising edge
//   rst     in   1      synchronous active-high reset (out, ovf -> 0)
//   in      in   WIDTH  operand, two's-complement
//   negBit  in   1      1 = negate, 0 = pass through
//   out     out  WIDTH  registered result, latency 1
//   ovf     out  1      registered overflow flag, only when NEG_2S_OVF_EN is
//                       defined: set when negating MIN_NEG (0x8000)
//
// Build option
//   NEG_2S_OVF_EN : adds the ovf port and its register. The out path is the
//                   same in both builds.
// -----------------------------------------------------------------------------
module neg_twos_16b
   import neg_2s_pkg::*;
#(
   parameter int WIDTH = DATA_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in,
   input  logic             negBit,
`ifdef NEG_2S_OVF_EN
   output logic             ovf,
`endif
   output logic [WIDTH-1:0] out
);

   // Invert stage: XOR every bit with negBit, so pass-through leaves the
   // word untouched and negate yields the one's complement.
   logic [WIDTH-1:0] inv_w;

   generate
      for (genvar gi = 0; gi < WIDTH; gi++) begin : g_inv
         assign inv_w[gi] = in[gi] ^ negBit;
      end
   endgenerate

   // Increment stage: carry-in is negBit, so the +1 of the two's complement
   // only happens when negating. The carry out of the MSB is dropped, which
   // gives the required wrap for 0x0000 (stays 0) and 0x8000 (maps to itself).
   logic [WIDTH-1:0] res_w;
   logic             unused_cout;

   inc_16b #(
      .W    (WIDTH)
   ) u_inc (
      .a    (inv_w),
      .cin  (negBit),
      .sum  (res_w),
      .cout (unused_cout)
   );

   // Output register: the only path to out, so out never follows the
   // inputs combinationally. Reset wins over any data on the same edge.
   logic [WIDTH-1:0] out_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         out_reg <= '0;
      end else begin
         out_reg <= res_w;
      end
   end

   assign out = out_reg;

`ifdef NEG_2S_OVF_EN
   // Only the most-negative word has no positive counterpart; flag it when
   // it is being negated. Registered alongside out so both share latency.
   logic ovf_next;
   logic ovf_reg;

   assign ovf_next = negBit && (in == WIDTH'(MIN_NEG));

   always_ff @(posedge clk) begin
      if (rst) begin
         ovf_reg <= 1'b0;
      end else begin
         ovf_reg <= ovf_next;
      end
   end

   assign ovf = ovf_reg;
`endif

endmodule : neg_twos_16b

// File: tb/tb_neg_twos_16b.sv
// -----------------------------------------------------------------------------
// tb_neg_twos_16b
//   Scoreboard bench for neg_twos_16b. Each cycle the bench drives inputs on
//   the falling edge and pushes the value out must hold after the next rising
//   edge; on the following falling edge that value is popped and compared.
//   Define NEG_2S_OVF_EN to also exercise the ovf flag.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_neg_twos_16b;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [15:0] in_s = 16'h0000;
   logic        neg_s = 1'b0;
   logic [15:0] out_s;
   logic        ovf_s;

   int checks   = 0;
   int failures = 0;

   // Scoreboard: one entry per driven cycle.
   string       q_tag[$];
   logic [15:0] q_out[$];
   logic        q_ovf[$];

   always #5 clk = ~clk;

   neg_twos_16b dut (
      .clk    (clk),
      .rst    (rst),
      .in     (in_s),
      .negBit (neg_s),
`ifdef NEG_2S_OVF_EN
      .ovf    (ovf_s),
`endif
      .out    (out_s)
   );

`ifndef NEG_2S_OVF_EN
   assign ovf_s = 1'b0;
`endif

   task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%04h expected 0x%04h", tag, obs, exp);
      end
   endtask

   // Compare the oldest pending expectation against the DUT's current output.
   task automatic flush_one();
      string       t;
      logic [15:0] e_out;
      logic        e_ovf;
      if (q_out.size() > 0) begin
         t     = q_tag.pop_front();
         e_out = q_out.pop_front();
         e_ovf = q_ovf.pop_front();
         $display("txn %-10s out=0x%04h exp=0x%04h ovf=%0b", t, out_s, e_out, ovf_s);
         check_val(t, out_s, e_out);
`ifdef NEG_2S_OVF_EN
         check_val({t, "_ovf"}, {15'b0, ovf_s}, {15'b0, e_ovf});
`endif
      end
   endtask

   // One cycle: check the previous cycle's result, then drive new inputs and
   // record what out must be after the coming rising edge.
   task automatic step(input string tag, input logic r, input logic [15:0] a, input logic n);
      logic [15:0] e_out;
      logic        e_ovf;
      @(negedge clk);
      flush_one();
      rst   = r;
      in_s  = a;
      neg_s = n;
      if (r) begin
         e_out = 16'h0000;
         e_ovf = 1'b0;
      end else begin
         e_out = n ? 16'(17'h10000 - {1'b0, a}) : a;
         e_ovf = n && (a == 16'h8000);
      end
      q_tag.push_back(tag);
      q_out.push_back(e_out);
      q_ovf.push_back(e_ovf);
   endtask

   initial begin
      logic [15:0] r_in;
      logic        r_neg;

      // 1: reset held for two edges while negate data is present
      step("reset0", 1'b1, 16'h1234, 1'b1);
      step("reset1", 1'b1, 16'h1234, 1'b1);

      // 2: pass-through
      step("pass5a5a", 1'b0, 16'h5A5A, 1'b0);
      step("pass8000", 1'b0, 16'h8000, 1'b0);

      // 3: negate
      step("neg0001", 1'b0, 16'h0001, 1'b1);
      step("neg0005", 1'b0, 16'h0005, 1'b1);
      step("negffff", 1'b0, 16'hFFFF, 1'b1);

      // 4: edge values
      step("neg0000", 1'b0, 16'h0000, 1'b1);
      step("neg8000", 1'b0, 16'h8000, 1'b1);
      step("neg7fff", 1'b0, 16'h7FFF, 1'b1);

      // 5: reset mid-stream discards the pending result
      step("mid_pre", 1'b0, 16'h0003, 1'b1);
      step("mid_rst", 1'b1, 16'h0003, 1'b1);
      step("mid_post", 1'b0, 16'h0003, 1'b1);

      // 6: random traffic
      for (int i = 0; i < 200; i++) begin
         r_in  = 16'($urandom);
         r_neg = 1'($urandom_range(0, 1));
         step("random", 1'b0, r_in, r_neg);
      end

      // Drain the last expectation.
      @(negedge clk);
      flush_one();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule : tb_neg_twos_16b
